// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one word-addressed data memory between the CPU data port (0)
// and the loader port (1); translates data-segment byte addresses and rejects illegal ones.
module dmem_arbiter #(
  parameter logic [31:0] DATA_BASE = 32'h1001_0000,
  parameter int          ADDR_W    = 10
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              DM_ena,
  output logic              DM_R,
  output logic              DM_W,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  state_t            state, state_next;
  logic              last_grant;
  logic              sel;
  logic              we;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       wdata;
  logic [31:0]       resp_data;

  logic              grant_any;
  logic              grant_sel;
  logic [31:0]       req_addr;
  logic [31:0]       req_offset;
  logic              req_legal;
  logic              in_access;
  logic              responding;
  logic [31:0]       rsp_data;

  // Arbitration and address check are evaluated on the live inputs of the port being granted;
  // only the resulting word index is latched, so later changes on the request side are ignored.
  always_comb begin
    grant_any  = m0_req | m1_req;
    grant_sel  = (m0_req && m1_req) ? ~last_grant : m1_req;
    req_addr   = grant_sel ? m1_addr : m0_addr;
    req_offset = req_addr - DATA_BASE;
    req_legal  = (req_offset[1:0] == 2'b00) && (req_offset[31:ADDR_W+2] == '0);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = req_legal ? ACCESS : ERR;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      sel        <= 1'b0;
      we         <= 1'b0;
      word_idx   <= '0;
      wdata      <= '0;
      resp_data  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_any) begin
        sel        <= grant_sel;
        last_grant <= grant_sel;
        we         <= grant_sel ? m1_we : m0_we;
        word_idx   <= req_offset[ADDR_W+1:2];
        wdata      <= grant_sel ? m1_wdata : m0_wdata;
        resp_data  <= '0;
      end
      if (state == ACCESS && !we) begin
        resp_data <= dm_rdata;
      end
    end
  end

  // All outputs decode from registered state, so an asynchronous reset clears them at once.
  always_comb begin
    in_access  = (state == ACCESS);
    responding = (state == RESP) || (state == ERR);
    rsp_data   = (state == RESP && !we) ? resp_data : 32'h0;

    DM_ena   = in_access;
    DM_R     = in_access & ~we;
    DM_W     = in_access & we;
    dm_addr  = in_access ? word_idx : '0;
    dm_wdata = in_access ? wdata : 32'h0;

    m0_ready = responding & ~sel;
    m0_err   = (state == ERR) & ~sel;
    m0_rdata = sel ? 32'h0 : rsp_data;
    m1_ready = responding & sel;
    m1_err   = (state == ERR) & sel;
    m1_rdata = sel ? rsp_data : 32'h0;

    busy = (state != IDLE);
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory (DMEM: async read, DM_ena/DM_R/DM_W strobes, word-addressed) between two requesters.
- Port 0 is the CPU data port; port 1 is the program/data loader (debug DMA).
- Translates byte addresses in the MIPS data segment to DMEM word indices and rejects illegal accesses.
- Arbitrates round-robin with a req/ready handshake. It sits between the CPU/loader and DMEM at the top level.

Parameters:
- DATA_BASE, 32'h1001_0000, byte address of DMEM word 0.
- ADDR_W, 10, DMEM word-index width; depth = 2^ADDR_W words.

Ports:
- clk_in  input  1  clock, rising edge.
- reset  input  1  asynchronous active-high reset.
- m0_req  input  1  port 0 request; held until m0_ready.
- m0_we  input  1  port 0: 1 = write, 0 = read.
- m0_addr  input  32  port 0 byte address.
- m0_wdata  input  32  port 0 write data.
- m0_ready  output  1  port 0 one-cycle completion pulse.
- m0_rdata  output  32  port 0 read data; valid while m0_ready is high.
- m0_err  output  1  port 0 error flag; valid with m0_ready.
- m1_req / m1_we / m1_addr / m1_wdata / m1_ready / m1_rdata / m1_err: same as port 0, for port 1.
- DM_ena  output  1  DMEM enable.
- DM_R  output  1  DMEM read strobe.
- DM_W  output  1  DMEM write strobe.
- dm_addr  output  ADDR_W  DMEM word index.
- dm_wdata  output  32  DMEM write data.
- dm_rdata  input  32  DMEM read data (combinational from dm_addr).
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - last_grant = 1, so port 0 wins the first tie.
  - All outputs 0, including the dm_* buses, m*_rdata, m*_err and busy.
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both reqs are high, grant the port != last_grant.
  - On grant, register sel, we, addr and wdata, and set last_grant = sel.
  - Then check the latched address, offset = addr - DATA_BASE (32-bit unsigned wrap):
    - legal if addr[1:0] == 0 and offset[31:2] < 2^ADDR_W, giving next state ACCESS;
    - illegal otherwise, giving next state ERR.
  - Addresses below DATA_BASE wrap to a large offset and are illegal.
- ACCESS (exactly 1 cycle):
  - DM_ena = 1; DM_R = ~we; DM_W = we.
  - dm_addr = offset[ADDR_W+1:2]; dm_wdata = latched wdata.
  - For a read, capture dm_rdata into the response register at the clock edge.
  - Next state RESP.
- RESP (1 cycle): pulse the selected port's ready with err = 0. rdata = captured data for a read, 0 for a write. Next state IDLE.
- ERR (1 cycle):
  - No DMEM strobes.
  - Pulse the selected port's ready with err = 1 and rdata = 0.
  - Next state IDLE.
- DMEM strobes are registered/decoded from state only and are never asserted outside ACCESS.
- dm_addr and dm_wdata return to 0 when not in ACCESS.
- Latency:
  - Legal access: req sampled at edge T (IDLE), ACCESS in cycle T+1, ready in cycle T+2.
  - Illegal access: ready in cycle T+1.
  - Minimum request-to-request spacing on a port is 3 cycles, since IDLE is re-entered for every transaction.
- Handshake:
  - A requester holds req/we/addr/wdata stable until its ready pulse.
  - A requester may keep req high to issue a back-to-back request; it is re-arbitrated in the next IDLE.
  - The non-granted port's ready, rdata and err stay 0.
  - Arbiter-side changes to req/addr after the grant edge are ignored (latched copy is used).
- Fairness:
  - With both ports continuously requesting, grants alternate 0,1,0,1 with no starvation.
  - A lone requester is granted every transaction regardless of last_grant.
- Reset mid-operation: asynchronous return to IDLE with all outputs 0 immediately (not at the next edge). An in-flight write in ACCESS is aborted, and no ready pulse is produced.

Test Plan:
- m0 reads 0x1001_0008 with DMEM word 2 = 0xDEADBEEF → DM_R = 1 and dm_addr = 2 in cycle T+1; m0_ready = 1, m0_rdata = 0xDEADBEEF, m0_err = 0 in cycle T+2.
- m1 writes 0x1234_5678 to 0x1001_0FFC (ADDR_W = 10) → DM_W = 1, dm_addr = 1023, dm_wdata = 0x1234_5678 for exactly one cycle; m1_ready at T+2; m0_ready stays 0.
- m0 and m1 both hold req high for 4 transactions from reset → grant order 0,1,0,1, each ready spaced 3 cycles apart.
- m0 accesses 0x1001_0002, then 0x1001_1000, then 0x0040_0000 → each gives m0_ready with m0_err = 1 at T+1, rdata = 0, and DM_ena never asserted.
- Assert reset while in ACCESS on a write → DM_W falls in the same cycle without waiting for a clock edge; no ready pulse; the next request after reset is served normally with port 0 winning a tie.
